// File: rtl/nios_setup_pkg.sv
// Shared definitions for the camera-sync LED strobe block: state encoding,
// LED and pulse counter widths, and the down-counter width helper.
package nios_setup_pkg;

    localparam int LED_W  = 5;
    localparam int PCNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DELAY   = 2'd1,
        ST_ON      = 2'd2,
        ST_HOLDOFF = 2'd3
    } strobe_state_t;

    // Width of a down-counter able to hold (largest phase length - 1).
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (c > m) ? c : m;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/nios_setup_sync_edge.sv
// Two-flop synchronizer for the asynchronous camera frame-sync, followed by
// a registered rising-edge detector. The detector stays disarmed after reset
// until a genuine (post-reset) low sample has been seen, so a sync line that
// is already high at reset release is not mistaken for an edge.
module nios_setup_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise_pulse
);

    logic sync_1;
    logic sync_2;
    logic prev;
    logic fill_1;
    logic fill_2;
    logic armed;

    // Synchronize, track pipeline fill, arm on a real low, emit 1-cycle rise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_1     <= 1'b0;
            sync_2     <= 1'b0;
            prev       <= 1'b0;
            fill_1     <= 1'b0;
            fill_2     <= 1'b0;
            armed      <= 1'b0;
            rise_pulse <= 1'b0;
        end else begin
            sync_1     <= async_in;
            sync_2     <= sync_1;
            prev       <= sync_2;
            fill_1     <= 1'b1;
            fill_2     <= fill_1;
            armed      <= armed | (fill_2 & ~sync_2);
            rise_pulse <= sync_2 & ~prev & armed;
        end
    end

endmodule

// File: rtl/nios_setup_led_strobe.sv
// LED strobe sequencer: on a camera frame-sync edge, wait DELAY_CYCLES, drive
// the latched LED pattern for WIDTH_CYCLES, then stay busy for HOLDOFF_CYCLES.
// Edges arriving while busy are dropped and flagged in a sticky overrun bit.
module nios_setup_led_strobe
    import nios_setup_pkg::*;
#(
    parameter int DELAY_CYCLES   = 16,
    parameter int WIDTH_CYCLES   = 64,
    parameter int HOLDOFF_CYCLES = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [LED_W-1:0]  led_pattern,
    input  logic              sync_in,
    input  logic              overrun_clr,
    output logic [LED_W-1:0]  led_drive,
    output logic              busy,
    output logic              overrun,
    output logic [PCNT_W-1:0] pulse_count
);

    localparam int CW = cnt_width(DELAY_CYCLES, WIDTH_CYCLES, HOLDOFF_CYCLES);

    // Each phase loads (length - 1) and leaves when the counter reads zero.
    localparam logic [CW-1:0] DELAY_LOAD =
        (DELAY_CYCLES > 0) ? CW'(DELAY_CYCLES - 1) : '0;
    localparam logic [CW-1:0] WIDTH_LOAD = CW'(WIDTH_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LOAD  =
        (HOLDOFF_CYCLES > 0) ? CW'(HOLDOFF_CYCLES - 1) : '0;

    strobe_state_t     state;
    strobe_state_t     state_nxt;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_nxt;
    logic [LED_W-1:0]  pattern;
    logic [LED_W-1:0]  pattern_nxt;
    logic [LED_W-1:0]  led_nxt;
    logic              busy_nxt;
    logic              overrun_nxt;
    logic [PCNT_W-1:0] count_nxt;
    logic              enter_on;
    logic              ovr_set;
    logic              rise_pulse;

    nios_setup_sync_edge u_sync_edge (
        .clk        (clk),
        .reset      (reset),
        .async_in   (sync_in),
        .rise_pulse (rise_pulse)
    );

    // Next-state, counter reload and registered-output precomputation.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        pattern_nxt = pattern;
        enter_on    = 1'b0;
        ovr_set     = enable & rise_pulse & (state != ST_IDLE);

        if (!enable) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rise_pulse) begin
                        pattern_nxt = led_pattern;
                        if (DELAY_CYCLES == 0) begin
                            state_nxt = ST_ON;
                            cnt_nxt   = WIDTH_LOAD;
                            enter_on  = 1'b1;
                        end else begin
                            state_nxt = ST_DELAY;
                            cnt_nxt   = DELAY_LOAD;
                        end
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
                ST_DELAY: begin
                    if (cnt == '0) begin
                        state_nxt = ST_ON;
                        cnt_nxt   = WIDTH_LOAD;
                        enter_on  = 1'b1;
                    end else begin
                        cnt_nxt = cnt - CW'(1);
                    end
                end
                ST_ON: begin
                    if (cnt == '0) begin
                        if (HOLDOFF_CYCLES > 0) begin
                            state_nxt = ST_HOLDOFF;
                            cnt_nxt   = HOLD_LOAD;
                        end else begin
                            state_nxt = ST_IDLE;
                            cnt_nxt   = '0;
                        end
                    end else begin
                        cnt_nxt = cnt - CW'(1);
                    end
                end
                ST_HOLDOFF: begin
                    if (cnt == '0) begin
                        state_nxt = ST_IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt - CW'(1);
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end

        led_nxt     = (state_nxt == ST_ON) ? pattern_nxt : '0;
        busy_nxt    = (state_nxt != ST_IDLE);
        count_nxt   = enter_on ? (pulse_count + PCNT_W'(1)) : pulse_count;
        overrun_nxt = ovr_set ? 1'b1 : (overrun_clr ? 1'b0 : overrun);
    end

    // State, counter, latched pattern and all outputs registered together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            pattern     <= '0;
            led_drive   <= '0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
            pulse_count <= '0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            pattern     <= pattern_nxt;
            led_drive   <= led_nxt;
            busy        <= busy_nxt;
            overrun     <= overrun_nxt;
            pulse_count <= count_nxt;
        end
    end

endmodule

// File: tb/tb_nios_setup_led_strobe.sv
// Bench for the LED strobe: two instances (default timing, and zero delay /
// one-cycle width / zero holdoff) checked every cycle against a timeline
// model, plus hand-computed spot checks for the directed scenarios.
module tb_nios_setup_led_strobe;

    localparam int NI = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       en   [NI];
    logic [4:0] pat  [NI];
    logic       syn  [NI];
    logic       clr  [NI];
    logic [4:0] led  [NI];
    logic       bsy  [NI];
    logic       ovr  [NI];
    logic [15:0] cnt [NI];

    int vectors     = 0;
    int miscompares = 0;

    // Model state: active strobe, cycles since acceptance, latched pattern.
    bit         m_act  [NI];
    int         m_t    [NI];
    logic [4:0] m_lat  [NI];
    logic [15:0] m_cnt [NI];
    logic       m_ovr  [NI];
    logic       m_hist [NI][5];

    always #5 clk = ~clk;

    nios_setup_led_strobe dut0 (
        .clk(clk), .reset(reset), .enable(en[0]), .led_pattern(pat[0]),
        .sync_in(syn[0]), .overrun_clr(clr[0]), .led_drive(led[0]),
        .busy(bsy[0]), .overrun(ovr[0]), .pulse_count(cnt[0])
    );

    nios_setup_led_strobe #(
        .DELAY_CYCLES(0), .WIDTH_CYCLES(1), .HOLDOFF_CYCLES(0)
    ) dut1 (
        .clk(clk), .reset(reset), .enable(en[1]), .led_pattern(pat[1]),
        .sync_in(syn[1]), .overrun_clr(clr[1]), .led_drive(led[1]),
        .busy(bsy[1]), .overrun(ovr[1]), .pulse_count(cnt[1])
    );

    function automatic int p_d(input int i); return (i == 0) ? 16 : 0; endfunction
    function automatic int p_w(input int i); return (i == 0) ? 64 : 1; endfunction
    function automatic int p_h(input int i); return (i == 0) ? 8  : 0; endfunction

    task automatic check(input string nm, input int i,
                         input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s[%0d]: got %h, expected %h at %0t", nm, i, act, exp, $time);
        end
    endtask

    // One clock edge of the model: an edge is a low sample followed by a high
    // sample, seen by the sequencer 3 edges after the high sample; samples
    // from before reset release count as high.
    task automatic model_step(input int i);
        bit rise;
        int d, w, h;
        d = p_d(i); w = p_w(i); h = p_h(i);
        if (reset) begin
            m_act[i] = 1'b0; m_t[i] = 0; m_lat[i] = 5'd0;
            m_cnt[i] = 16'd0; m_ovr[i] = 1'b0;
            for (int k = 0; k < 5; k++) m_hist[i][k] = 1'b1;
        end else begin
            for (int k = 4; k > 0; k--) m_hist[i][k] = m_hist[i][k-1];
            m_hist[i][0] = syn[i];
            rise = m_hist[i][3] && !m_hist[i][4];
            if (!en[i]) begin
                m_act[i] = 1'b0;
                if (clr[i]) m_ovr[i] = 1'b0;
            end else if (m_act[i]) begin
                if (rise) m_ovr[i] = 1'b1;
                else if (clr[i]) m_ovr[i] = 1'b0;
                m_t[i] = m_t[i] + 1;
                if (m_t[i] >= d + w + h) m_act[i] = 1'b0;
                else if (m_t[i] == d) m_cnt[i] = m_cnt[i] + 16'd1;
            end else begin
                if (clr[i]) m_ovr[i] = 1'b0;
                if (rise) begin
                    m_act[i] = 1'b1; m_t[i] = 0; m_lat[i] = pat[i];
                    if (d == 0) m_cnt[i] = m_cnt[i] + 16'd1;
                end
            end
        end
    endtask

    function automatic logic [4:0] exp_led(input int i);
        if (m_act[i] && m_t[i] >= p_d(i) && m_t[i] < p_d(i) + p_w(i)) return m_lat[i];
        return 5'd0;
    endfunction

    // Per-cycle compare of both instances against the model.
    initial begin
        forever begin
            @(posedge clk);
            for (int i = 0; i < NI; i++) model_step(i);
            #1;
            for (int i = 0; i < NI; i++) begin
                check("led_drive",   i, {11'd0, led[i]}, {11'd0, exp_led(i)});
                check("busy",        i, {15'd0, bsy[i]}, {15'd0, m_act[i]});
                check("overrun",     i, {15'd0, ovr[i]}, {15'd0, m_ovr[i]});
                check("pulse_count", i, cnt[i], m_cnt[i]);
            end
        end
    end

    task automatic negs(input int n); repeat (n) @(negedge clk); endtask
    task automatic edges(input int n); repeat (n) @(posedge clk); #2; endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < NI; i++) begin
            en[i] = 1'b0; pat[i] = 5'd0; syn[i] = 1'b0; clr[i] = 1'b0;
        end
        negs(3);
        reset = 1'b0;
        en[0] = 1'b1; en[1] = 1'b1;
        negs(8);

        // Default timing: LEDs on for edges 20..83, idle at edge 92.
        pat[0] = 5'b10101; syn[0] = 1'b1;
        edges(19); check("s1_led_e19", 0, {11'd0, led[0]}, 16'h0000);
        edges(1);  check("s1_led_e20", 0, {11'd0, led[0]}, 16'h0015);
        edges(63); check("s1_led_e83", 0, {11'd0, led[0]}, 16'h0015);
        edges(1);  check("s1_led_e84", 0, {11'd0, led[0]}, 16'h0000);
        edges(7);  check("s1_busy_e91", 0, {15'd0, bsy[0]}, 16'h0001);
        edges(1);  check("s1_busy_e92", 0, {15'd0, bsy[0]}, 16'h0000);
        check("s1_count", 0, cnt[0], 16'd1);
        @(negedge clk); syn[0] = 1'b0; negs(4);

        // Edge during ON sets overrun; clear; clear coinciding with set.
        pat[0] = 5'b01110; syn[0] = 1'b1; negs(3); syn[0] = 1'b0; negs(25);
        syn[0] = 1'b1; negs(2); syn[0] = 1'b0; negs(3);
        edges(1);
        check("s2_ovr_set", 0, {15'd0, ovr[0]}, 16'h0001);
        check("s2_count", 0, cnt[0], 16'd2);
        @(negedge clk); clr[0] = 1'b1;
        @(negedge clk); clr[0] = 1'b0;
        #1 check("s2_ovr_clr", 0, {15'd0, ovr[0]}, 16'h0000);
        @(negedge clk); syn[0] = 1'b1; negs(3); clr[0] = 1'b1;
        @(negedge clk); clr[0] = 1'b0; syn[0] = 1'b0;
        #1 check("s2_set_wins", 0, {15'd0, ovr[0]}, 16'h0001);
        check("s2_count2", 0, cnt[0], 16'd2);
        negs(60);
        clr[0] = 1'b1; negs(1); clr[0] = 1'b0; negs(2);

        // Pattern change mid-ON is ignored until the next strobe.
        pat[0] = 5'b00011; syn[0] = 1'b1; negs(3); syn[0] = 1'b0; negs(25);
        pat[0] = 5'b11000;
        edges(1); check("s3_led_hold", 0, {11'd0, led[0]}, 16'h0003);
        @(negedge clk); negs(70);
        syn[0] = 1'b1; negs(3); syn[0] = 1'b0; negs(25);
        #1 check("s3_led_new", 0, {11'd0, led[0]}, 16'h0018);
        check("s3_count", 0, cnt[0], 16'd4);
        negs(70);

        // Enable dropped in DELAY: back to idle, no LEDs, count kept.
        pat[0] = 5'b11111; syn[0] = 1'b1; negs(3); syn[0] = 1'b0; negs(5);
        en[0] = 1'b0;
        #1 check("s4_busy_pre", 0, {15'd0, bsy[0]}, 16'h0001);
        edges(1);
        check("s4_busy_off", 0, {15'd0, bsy[0]}, 16'h0000);
        check("s4_count", 0, cnt[0], 16'd4);
        @(negedge clk); syn[0] = 1'b1; negs(3); syn[0] = 1'b0; negs(30);
        #1 check("s4_no_ovr", 0, {15'd0, ovr[0]}, 16'h0000);
        check("s4_count2", 0, cnt[0], 16'd4);
        en[0] = 1'b1; negs(5);

        // Zero delay/holdoff, one-cycle width: pulse at edge 4, rearm by edge 9.
        @(negedge clk); pat[1] = 5'b11111; syn[1] = 1'b1;
        negs(2); syn[1] = 1'b0;
        edges(1); check("s5_led_e3", 1, {11'd0, led[1]}, 16'h0000);
        edges(1); check("s5_led_e4", 1, {11'd0, led[1]}, 16'h001F);
        check("s5_count", 1, cnt[1], 16'd1);
        edges(1); check("s5_led_e5", 1, {11'd0, led[1]}, 16'h0000);
        check("s5_busy_e5", 1, {15'd0, bsy[1]}, 16'h0000);
        @(negedge clk); pat[1] = 5'b00110; syn[1] = 1'b1;
        negs(2); syn[1] = 1'b0;
        edges(2); check("s5_led_e9", 1, {11'd0, led[1]}, 16'h0006);
        check("s5_no_ovr", 1, {15'd0, ovr[1]}, 16'h0000);
        check("s5_count2", 1, cnt[1], 16'd2);
        negs(4);

        // Counter wrap: preload near the top, two more strobes.
        @(negedge clk);
        force dut1.pulse_count = 16'hFFFE;
        m_cnt[1] = 16'hFFFE;
        @(negedge clk);
        release dut1.pulse_count;
        negs(2);
        syn[1] = 1'b1; negs(1); syn[1] = 1'b0; negs(6);
        #1 check("s6_count_ffff", 1, cnt[1], 16'hFFFF);
        syn[1] = 1'b1; negs(1); syn[1] = 1'b0; negs(6);
        #1 check("s6_count_wrap", 1, cnt[1], 16'h0000);

        // Reset during ON drops LEDs at once; sync held high is not an edge.
        pat[0] = 5'b10101; syn[0] = 1'b1; negs(30);
        check("s7_led_pre", 0, {11'd0, led[0]}, 16'h0015);
        reset = 1'b1;
        #1;
        check("s7_led_async", 0, {11'd0, led[0]}, 16'h0000);
        check("s7_busy_async", 0, {15'd0, bsy[0]}, 16'h0000);
        check("s7_count_async", 0, cnt[0], 16'h0000);
        check("s7_count1_async", 1, cnt[1], 16'h0000);
        negs(2); reset = 1'b0; negs(30);
        #1 check("s7_no_strobe", 0, {15'd0, bsy[0]}, 16'h0000);
        check("s7_count_rel", 0, cnt[0], 16'h0000);
        syn[0] = 1'b0; negs(3); syn[0] = 1'b1; negs(6);
        #1 check("s7_rearmed", 0, {15'd0, bsy[0]}, 16'h0001);
        negs(20);
        #1 check("s7_count_new", 0, cnt[0], 16'd1);
        negs(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/nios_setup_led_strobe.md
NIOS_SETUP_LED_STROBE -- requirements
Module: nios_setup_led_strobe

Interface
REQ-001 SHALL have parameter DELAY_CYCLES, default 16: clk cycles from detected sync edge to LED on (0 allowed).
REQ-002 SHALL have parameter WIDTH_CYCLES, default 64: clk cycles LEDs stay on (legal range >= 1).
REQ-003 SHALL have parameter HOLDOFF_CYCLES, default 8: clk cycles of dead time after LEDs turn off (0 allowed).
REQ-004 SHALL have port clk, input, 1: the single block clock.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port enable, input, 1: strobe enable; low forces idle.
REQ-007 SHALL have port led_pattern, input, 5: LED select mask, driven by the LED PIO out_port.
REQ-008 SHALL have port sync_in, input, 1: external camera frame-sync, asynchronous to clk.
REQ-009 SHALL have port overrun_clr, input, 1: single-cycle clear of the overrun flag.
REQ-010 SHALL have port led_drive, output, 5: strobed LED drive lines.
REQ-011 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-012 SHALL have port overrun, output, 1: sticky flag for a sync edge arriving while busy.
REQ-013 SHALL have port pulse_count, output, 16: number of strobes issued.

Function
REQ-014 SHALL pass sync_in through a 2-flop synchronizer followed by a registered rising-edge detector, so rise_pulse is high for exactly 1 cycle, 3 clk edges after sync_in is first sampled high.
REQ-015 SHALL implement states IDLE, DELAY, ON and HOLDOFF.
REQ-016 On rise_pulse in IDLE with enable high, SHALL latch led_pattern and enter DELAY, or ON directly if DELAY_CYCLES == 0.
REQ-017 SHALL stay in DELAY exactly DELAY_CYCLES cycles, in ON exactly WIDTH_CYCLES cycles, and in HOLDOFF exactly HOLDOFF_CYCLES cycles; HOLDOFF is skipped when HOLDOFF_CYCLES == 0.
REQ-018 SHALL leave HOLDOFF for IDLE.
REQ-019 SHALL register led_drive, equal to the latched pattern while in ON and 0 otherwise.
REQ-020 SHALL ignore led_pattern changes after the latch; a new value takes effect at the next strobe only.
REQ-021 SHALL, when the latched pattern is 0, still run the full sequence and count it, with led_drive remaining 0.
REQ-022 SHALL increment pulse_count on entry to ON, wrapping from 16'hFFFF to 0.
REQ-023 SHALL, on rise_pulse in any state other than IDLE, ignore the edge and set overrun.
REQ-024 SHALL, when enable is low, not register an edge as overrun.
REQ-025 SHALL let overrun_clr clear overrun, except that a simultaneous set wins.
REQ-026 SHALL, on enable low in any state, go to IDLE on the next edge and force led_drive to 0; pulse_count and overrun are preserved.
REQ-027 SHALL use one down-counter, wide enough for the largest parameter, reloaded on each state entry.

Reset
REQ-028 SHALL, on reset assertion, asynchronously clear: state to IDLE, led_drive 0, busy 0, overrun 0, pulse_count 0, latched pattern 0, synchronizer and edge flops 0, counter 0.
REQ-029 SHALL, when reset is asserted mid-strobe, drop LEDs immediately without waiting for a clk edge.
REQ-030 SHALL NOT, after reset release, treat a sync_in already high as an edge until it has been seen low.

Structure
REQ-031 SHALL place the state encoding constants, the LED width (5) and the pulse_count width (16) in the shared nios_setup package/include.
REQ-032 SHALL implement the synchronizer and edge detector as sub-module nios_setup_sync_edge (ports clk, reset, async_in, rise_pulse).

Verification
REQ-033 Directed scenario, default parameters: pattern 5'b10101, sync_in rising at cycle 0 -> led_drive = 10101 for cycles 20..83, busy low at cycle 92, pulse_count = 1.
REQ-034 Directed scenario: second sync edge during ON -> overrun = 1, pulse_count unchanged; overrun_clr pulsed at the same cycle as a third busy-time edge -> overrun stays 1.
REQ-035 Directed scenario: led_pattern changed from 5'b00011 to 5'b11000 mid-ON -> led_drive holds 00011; the next strobe shows 11000.
REQ-036 Directed scenario: DELAY_CYCLES=0, HOLDOFF_CYCLES=0, WIDTH_CYCLES=1 -> a single-cycle pulse 4 cycles after the sync edge; back-to-back edges 5 cycles apart yield no overrun.
REQ-037 Directed scenario: reset asserted during ON -> led_drive = 0 before the next clk edge and all outputs 0; sync_in held high through release -> no strobe.
REQ-038 Directed scenario: pulse_count preloaded near wrap (65535 strobes, or forced) -> the next strobe reads 0; enable dropped during DELAY -> IDLE, no LED activity, count unchanged.
